// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds and occupancy count
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     led,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              led_q, led_d;
  logic              wr_acc, rd_acc;

  // Status flags decode the registered count only, so they never glitch mid-cycle.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign data_out     = data_out_q;
  assign led          = led_q;

  always_comb begin
    wr_acc     = wr_en && !full;
    rd_acc     = rd_en && !empty;
    wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    data_out_d = rd_acc ? mem[rd_ptr_q] : data_out_q;
    led_d      = full;
    count_d    = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      led_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      led_q      <= led_d;
    end
  end

  // Storage is deliberately unreset; empty keeps stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO that succeeds the fixed 8x8 FIFO in the verification projects. It has configurable data width and depth, programmable almost-full and almost-empty thresholds, and an exported occupancy count. Simultaneous read and write are handled correctly at any fill level, and optional sticky overflow/underflow error flags are available. It sits between a single-clock producer and consumer as the standard buffering block for later designs and their testbenches.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports (CW = $clog2(DEPTH)+1):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_in  in  DATA_W  write data, sampled on an accepted write
- data_out  out  DATA_W  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH
- led  out  1  registered copy of full, one cycle late
- overflow  out  1  sticky error flag: write attempted while full
- underflow  out  1  sticky error flag: read attempted while empty

## Operation
- Write accept: wr_en && !full, evaluated on pre-edge state. Stores data_in at wr_ptr; wr_ptr increments.
- Read accept: rd_en && !empty, evaluated on pre-edge state. data_out <= mem[rd_ptr]; rd_ptr increments.
- Count update per edge: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Both requests while full: read accepted, write rejected; count becomes DEPTH-1.
- Both requests while empty: write accepted, read rejected; data_out holds; count becomes 1. No bypass.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- data_out holds its value when no read is accepted.
- full, empty, almost_full and almost_empty are combinational from count.
- Rejected requests do not change pointers, count, memory or data_out.
- Memory contents are not reset. After reset, stale entries are never readable because empty gates reads.

## Timing
- Reset (async assert, takes effect immediately): wr_ptr=0, rd_ptr=0, count=0, data_out=0, led=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_empty=1, and almost_full = (AF_LEVEL==0, i.e. 0).
- Reset asserted mid-operation discards all contents. The first write after reset deassertion is accepted on the next edge.
- Read latency: data_out is valid after the same edge at which the read is accepted (1 cycle from rd_en).
- Write-to-read: a word written at edge N can be read at edge N+1 (empty deasserts after edge N).
- Flags and count change only after a clock edge or asynchronously on reset; never within a cycle.
- led lags full by one clock.

## Configuration
- SYNC_FIFO_ERR_EN defined:
  - overflow sets at any edge where wr_en && full.
  - underflow sets at any edge where rd_en && empty.
  - Both flags are sticky until rst.
- SYNC_FIFO_ERR_EN undefined:
  - overflow and underflow are tied to constant 0.
  - The ports remain present.
- FIFO data behaviour is identical in both builds.

## Test plan
- Reset then fill (defaults): write 0x01..0x08 on 8 cycles. Requirements: count steps 1..8; almost_full at count 7; full at count 8; led high one cycle after full; a 9th write is ignored, count stays 8, overflow=1 (with SYNC_FIFO_ERR_EN).
- Drain in order after the fill above: 8 reads return 0x01..0x08 with 1-cycle latency. empty=1 after the 8th read; a 9th read leaves data_out=0x08 and sets underflow=1.
- Wrap-around: repeat 3 rounds of write-5 / read-5 with distinct data. Data stays in order across pointer wrap; count returns to 0 each round.
- Simultaneous read/write:
  - Count 4, both asserted for 10 cycles: count stays 4 and output data stays in order.
  - Full, both asserted: count becomes 7 and the write data is dropped.
  - Empty, both asserted: count becomes 1, data_out is unchanged, and the word is readable next cycle.
- Reset mid-operation: with count=5, pulse rst between edges. All outputs take reset values immediately; the next read attempt is rejected; overflow/underflow are cleared.
- Parameter sweep with DATA_W=16, DEPTH=16, AF_LEVEL=12, AE_LEVEL=3: almost_full at count 12, almost_empty deasserts at count 4, full at 16, 0xBEEF round-trips intact.
